// File: rtl/ttt_tick_scheduler_if.sv
// Host-side handshakes of the tick scheduler: input token beats towards the core
// and captured core events back to the host.
interface ttt_tick_scheduler_if #(
  parameter int NUM_PROCESSORS = 10,
  parameter int NEW_TOKEN_BITS = 4
);
  localparam int PID_W = $clog2(NUM_PROCESSORS);

  logic                             in_valid;
  logic                             in_ready;
  logic [PID_W-1:0]                 in_processor_id;
  logic signed [NEW_TOKEN_BITS-1:0] in_good;
  logic signed [NEW_TOKEN_BITS-1:0] in_bad;
  logic                             ev_valid;
  logic                             ev_ready;
  logic [PID_W-1:0]                 ev_processor_id;
  logic [1:0]                       ev_startstop;

  modport master (
    output in_valid, in_processor_id, in_good, in_bad, ev_ready,
    input  in_ready, ev_valid, ev_processor_id, ev_startstop
  );

  modport slave (
    input  in_valid, in_processor_id, in_good, in_bad, ev_ready,
    output in_ready, ev_valid, ev_processor_id, ev_startstop
  );
endinterface

// File: rtl/ttt_tick_scheduler.sv
// Drives the TTT core through one INPUT/UPDATE/OUTPUT tick per programmed period,
// forwarding host token beats and collecting core events into a one-entry slot.
module ttt_tick_scheduler #(
  parameter int NUM_PROCESSORS = 10,
  parameter int NEW_TOKEN_BITS = 4,
  localparam int PID_W = $clog2(NUM_PROCESSORS)
) (
  input  logic                             clock_fast,
  input  logic                             reset,
  input  logic                             run,
  input  logic [7:0]                       tick_period,
  ttt_tick_scheduler_if.slave              host,
  output logic [1:0]                       stage,
  output logic                             clock_slow,
  output logic [PID_W-1:0]                 core_processor_id,
  output logic signed [NEW_TOKEN_BITS-1:0] core_good_tokens,
  output logic signed [NEW_TOKEN_BITS-1:0] core_bad_tokens,
  input  logic                             core_output_valid,
  input  logic [1:0]                       core_token_startstop,
  output logic                             overrun
);
  typedef enum logic [1:0] {
    ST_INPUT  = 2'd0,
    ST_UPDATE = 2'd1,
    ST_OUTPUT = 2'd2,
    ST_IDLE   = 2'd3
  } state_t;

  localparam logic [PID_W-1:0] LAST_PID = PID_W'(NUM_PROCESSORS - 1);
  localparam logic [PID_W:0]   NUM_PIDS = (PID_W + 1)'(NUM_PROCESSORS);

  state_t           r_state;
  logic [7:0]       r_cnt;
  logic [PID_W-1:0] r_pid;
  logic [PID_W-1:0] r_acc;
  logic             r_done;
  logic             r_clock_slow;
  logic             r_overrun;
  logic             r_ev_valid;
  logic [PID_W-1:0] r_ev_pid;
  logic [1:0]       r_ev_code;

  logic [7:0] w_period;
  logic       w_start;
  logic       w_slot_free;
  logic       w_sample;
  logic       w_tick_end;
  logic       w_late;
  logic       w_in_forward;

  assign w_period     = (tick_period == 8'd0) ? 8'd1 : tick_period;
  assign w_start      = (r_state == ST_IDLE) && run && (r_cnt >= (w_period - 8'd1));
  assign w_slot_free  = !r_ev_valid || host.ev_ready;
  assign w_sample     = (r_state == ST_OUTPUT) && !r_done && w_slot_free;
  // The tick ends once every pid is sampled and the slot will be empty after this edge.
  assign w_tick_end   = (r_state == ST_OUTPUT) && w_slot_free &&
                        (r_done || ((r_pid == LAST_PID) && !core_output_valid));
  assign w_late       = ({1'b0, r_cnt} + 9'd1) > {1'b0, w_period};
  assign w_in_forward = (r_state == ST_INPUT) && host.in_valid &&
                        ({1'b0, host.in_processor_id} < NUM_PIDS);

  // Tick sequencer: phase state, pid scan, cycle counter, event slot and overrun flag.
  always_ff @(posedge clock_fast or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_pid        <= '0;
      r_acc        <= '0;
      r_done       <= 1'b0;
      r_clock_slow <= 1'b0;
      r_overrun    <= 1'b0;
      r_ev_valid   <= 1'b0;
      r_ev_pid     <= '0;
      r_ev_code    <= 2'd0;
    end else begin
      r_clock_slow <= 1'b0;
      if (r_cnt != 8'd255) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_tick_end && w_late) begin
        r_overrun <= 1'b1;
      end
      if (w_sample && core_output_valid) begin
        r_ev_valid <= 1'b1;
        r_ev_pid   <= r_pid;
        r_ev_code  <= core_token_startstop;
      end else if ((r_state == ST_OUTPUT) && w_slot_free) begin
        r_ev_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state      <= ST_INPUT;
            r_clock_slow <= 1'b1;
            r_cnt        <= 8'd0;
            r_acc        <= '0;
          end
        end
        ST_INPUT: begin
          if (!host.in_valid || (r_acc == LAST_PID)) begin
            r_state <= ST_UPDATE;
            r_pid   <= '0;
          end else begin
            r_acc <= r_acc + PID_W'(1);
          end
        end
        ST_UPDATE: begin
          if (r_pid == LAST_PID) begin
            r_state <= ST_OUTPUT;
            r_pid   <= '0;
            r_done  <= 1'b0;
          end else begin
            r_pid <= r_pid + PID_W'(1);
          end
        end
        ST_OUTPUT: begin
          if (w_tick_end) begin
            r_state <= ST_IDLE;
            r_pid   <= '0;
            r_done  <= 1'b0;
          end else if (w_sample) begin
            if (r_pid == LAST_PID) begin
              r_pid  <= '0;
              r_done <= 1'b1;
            end else begin
              r_pid <= r_pid + PID_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign stage                = r_state;
  assign clock_slow           = r_clock_slow;
  assign overrun              = r_overrun;
  assign host.in_ready        = (r_state == ST_INPUT);
  assign host.ev_valid        = r_ev_valid;
  assign host.ev_processor_id = r_ev_pid;
  assign host.ev_startstop    = r_ev_code;
  assign core_processor_id    = (r_state == ST_INPUT) ? host.in_processor_id : r_pid;
  assign core_good_tokens     = w_in_forward ? host.in_good : '0;
  assign core_bad_tokens      = w_in_forward ? host.in_bad  : '0;
endmodule

// File: tb/tb_ttt_tick_scheduler.sv
// Bench for ttt_tick_scheduler: a time-stamp/queue model of each tick checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ttt_tick_scheduler;
  localparam int N  = 10;
  localparam int TB = 4;
  localparam int PW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 run = 1'b0;
  logic [7:0]           tick_period = 8'd40;
  logic [1:0]           stage;
  logic                 clock_slow;
  logic                 overrun;
  logic                 core_output_valid;
  logic [PW-1:0]        core_pid;
  logic signed [TB-1:0] core_good;
  logic signed [TB-1:0] core_bad;
  logic [1:0]           core_code;

  logic       ev_en       [16];
  logic [1:0] ev_code_map [16];

  int checks = 0;
  int errors = 0;

  ttt_tick_scheduler_if #(.NUM_PROCESSORS(N), .NEW_TOKEN_BITS(TB)) host_if ();

  ttt_tick_scheduler #(.NUM_PROCESSORS(N), .NEW_TOKEN_BITS(TB)) dut (
    .clock_fast           (clk),
    .reset                (rst_n),
    .run                  (run),
    .tick_period          (tick_period),
    .host                 (host_if),
    .stage                (stage),
    .clock_slow           (clock_slow),
    .core_processor_id    (core_pid),
    .core_good_tokens     (core_good),
    .core_bad_tokens      (core_bad),
    .core_output_valid    (core_output_valid),
    .core_token_startstop (core_code),
    .overrun              (overrun)
  );

  always #5 clk = ~clk;

  // Core stand-in: reports an event for the addressed pid during OUTPUT.
  assign core_output_valid = (stage == 2'd2) && ev_en[core_pid];
  assign core_code         = ev_code_map[core_pid];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: tick described by time stamps and an event queue
  int         m_t = 0;
  int         m_t0 = 0;
  int         m_in_end = -1;
  int         m_beats = 0;
  int         m_next = 0;
  bit         m_in_tick = 1'b0;
  bit         m_overrun = 1'b0;
  logic [5:0] m_q[$];
  logic       s_run, s_in_valid, s_ev_ready, s_cov;
  logic [1:0] s_code;
  logic [7:0] s_period;

  function automatic int m_stage();
    if (!m_in_tick) return 3;
    if (m_in_end < 0) return 0;
    if (m_t < m_in_end + N) return 1;
    return 2;
  endfunction

  function automatic int m_cnt();
    int d;
    d = m_t - m_t0;
    return (d > 255) ? 255 : d;
  endfunction

  task automatic model_reset();
    m_t0 = m_t;
    m_in_tick = 1'b0;
    m_in_end = -1;
    m_beats = 0;
    m_next = 0;
    m_overrun = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    int st;
    int per;
    bit free;
    st  = m_stage();
    per = (s_period == 8'd0) ? 1 : int'(s_period);
    case (st)
      3: if (s_run && m_cnt() >= per - 1) begin
        m_in_tick = 1'b1;
        m_t0 = m_t + 1;
        m_in_end = -1;
        m_beats = 0;
        m_next = 0;
      end
      0: begin
        if (!s_in_valid) m_in_end = m_t + 1;
        else begin
          m_beats++;
          if (m_beats == N) m_in_end = m_t + 1;
        end
      end
      2: begin
        free = (m_q.size() == 0) || s_ev_ready;
        if (m_q.size() > 0 && s_ev_ready) void'(m_q.pop_front());
        if (m_next < N && free) begin
          if (s_cov) m_q.push_back({PW'(m_next), s_code});
          m_next++;
        end
        if (m_next == N && m_q.size() == 0) begin
          m_in_tick = 1'b0;
          if (m_t + 1 - m_t0 > per) m_overrun = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        model_step();
        m_t++;
      end
    end
  end

  // Every-cycle compare at the falling edge, then snapshot of this cycle's inputs.
  initial begin
    int st;
    int exp_pid;
    bit fwd;
    logic [5:0] e;
    forever begin
      @(negedge clk);
      st = m_stage();
      chk("stage", int'(stage), st);
      chk("clock_slow", int'(clock_slow), (m_in_tick && m_t == m_t0) ? 1 : 0);
      chk("in_ready", int'(host_if.in_ready), (st == 0) ? 1 : 0);
      chk("overrun", int'(overrun), int'(m_overrun));
      if (st == 0) exp_pid = int'(host_if.in_processor_id);
      else if (st == 1) exp_pid = m_t - m_in_end;
      else if (st == 2) exp_pid = m_next;
      else exp_pid = 0;
      if (!(st == 2 && m_next >= N)) chk("core_pid", int'(core_pid), exp_pid);
      fwd = (st == 0) && host_if.in_valid && (int'(host_if.in_processor_id) < N);
      chk("core_good", int'(unsigned'(core_good)), fwd ? int'(unsigned'(host_if.in_good)) : 0);
      chk("core_bad", int'(unsigned'(core_bad)), fwd ? int'(unsigned'(host_if.in_bad)) : 0);
      chk("ev_valid", int'(host_if.ev_valid), (m_q.size() > 0) ? 1 : 0);
      if (m_q.size() > 0) begin
        e = m_q[0];
        chk("ev_pid", int'(host_if.ev_processor_id), int'(e[5:2]));
        chk("ev_code", int'(host_if.ev_startstop), int'(e[1:0]));
      end
      s_run      = run;
      s_in_valid = host_if.in_valid;
      s_ev_ready = host_if.ev_ready;
      s_cov      = core_output_valid;
      s_code     = core_code;
      s_period   = tick_period;
    end
  end

  // ---------------- directed scenarios
  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_stage(input int v, input string name);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (int'(stage) != v && i < 300);
    chk(name, int'(stage), v);
  endtask

  task automatic count_to_slow(input int exp, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!clock_slow && n < 300);
    chk(name, n, exp);
  endtask

  task automatic set_beat(input logic v, input int id, input logic [3:0] g, input logic [3:0] b);
    host_if.in_valid        = v;
    host_if.in_processor_id = PW'(id);
    host_if.in_good         = g;
    host_if.in_bad          = b;
  endtask

  initial begin
    int k;
    int n_slow;
    for (int i = 0; i < 16; i++) begin
      ev_en[i] = 1'b0;
      ev_code_map[i] = 2'd0;
    end
    set_beat(1'b0, 0, 4'd0, 4'd0);
    host_if.ev_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stage", int'(stage), 3);
    chk("rst_ev_valid", int'(host_if.ev_valid), 0);
    chk("rst_in_ready", int'(host_if.in_ready), 0);
    chk("rst_core_pid", int'(core_pid), 0);
    chk("rst_overrun", int'(overrun), 0);
    #1;
    rst_n = 1'b1;
    run   = 1'b1;

    // No traffic, period 40
    count_to_slow(40, "first_tick_delay");
    for (int i = 0; i < 22; i++) begin
      chk("tick_shape", int'(stage), (i == 0) ? 0 : (i <= 10) ? 1 : (i <= 20) ? 2 : 3);
      @(negedge clk);
    end
    k = 22;
    while (!clock_slow && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("tick_period_40", k, 40);

    // Input forwarding
    wait_stage(3, "wait_idle_b");
    drive_slot();
    set_beat(1'b1, 2, 4'd3, 4'hF);
    k = 0;
    while (!host_if.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_seen", int'(host_if.in_ready), 1);
    chk("fwd1_pid", int'(core_pid), 2);
    chk("fwd1_good", int'(unsigned'(core_good)), 3);
    chk("fwd1_bad", int'(unsigned'(core_bad)), 15);
    drive_slot();
    set_beat(1'b1, 5, 4'd1, 4'd0);
    @(negedge clk);
    chk("fwd2_pid", int'(core_pid), 5);
    chk("fwd2_good", int'(unsigned'(core_good)), 1);
    chk("fwd2_bad", int'(unsigned'(core_bad)), 0);
    drive_slot();
    set_beat(1'b1, 12, 4'd7, 4'd7);
    @(negedge clk);
    chk("fwd3_pid", int'(core_pid), 12);
    chk("fwd3_good", int'(unsigned'(core_good)), 0);
    chk("fwd3_bad", int'(unsigned'(core_bad)), 0);
    drive_slot();
    set_beat(1'b0, 0, 4'd0, 4'd0);
    @(negedge clk);
    chk("fwd_close_stage", int'(stage), 0);
    @(negedge clk);
    chk("fwd_update_stage", int'(stage), 1);
    chk("fwd_update_pid", int'(core_pid), 0);

    // Events with backpressure
    wait_stage(3, "wait_idle_c");
    drive_slot();
    ev_en[3] = 1'b1;
    ev_code_map[3] = 2'd2;
    ev_en[4] = 1'b1;
    ev_code_map[4] = 2'd1;
    host_if.ev_ready = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!host_if.ev_valid && k < 200);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_ev_valid", int'(host_if.ev_valid), 1);
      chk("bp_ev_pid", int'(host_if.ev_processor_id), 3);
      chk("bp_ev_code", int'(host_if.ev_startstop), 2);
      chk("bp_stall_pid", int'(core_pid), 4);
    end
    drive_slot();
    host_if.ev_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_pid", int'(host_if.ev_processor_id), 3);
    @(negedge clk);
    chk("b2b_ev_valid", int'(host_if.ev_valid), 1);
    chk("b2b_ev_pid", int'(host_if.ev_processor_id), 4);
    chk("b2b_ev_code", int'(host_if.ev_startstop), 1);
    wait_stage(3, "wait_idle_d");
    drive_slot();
    ev_en[3] = 1'b0;
    ev_en[4] = 1'b0;

    // run dropped mid-UPDATE
    wait_stage(1, "wait_update_d");
    drive_slot();
    run = 1'b0;
    wait_stage(3, "run_drop_completes");
    n_slow = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (clock_slow) n_slow++;
    end
    chk("run_drop_no_tick", n_slow, 0);
    drive_slot();
    run = 1'b1;

    // Reset mid-OUTPUT with a held event
    drive_slot();
    ev_en[2] = 1'b1;
    ev_code_map[2] = 2'd3;
    host_if.ev_ready = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(host_if.ev_valid && stage == 2'd2) && k < 300);
    chk("pre_reset_ev_valid", int'(host_if.ev_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_stage", int'(stage), 3);
    chk("arst_ev_valid", int'(host_if.ev_valid), 0);
    chk("arst_ev_pid", int'(host_if.ev_processor_id), 0);
    chk("arst_ev_code", int'(host_if.ev_startstop), 0);
    chk("arst_clock_slow", int'(clock_slow), 0);
    chk("arst_core_pid", int'(core_pid), 0);
    chk("arst_core_good", int'(unsigned'(core_good)), 0);
    drive_slot();
    tick_period = 8'd15;
    ev_en[2] = 1'b0;
    host_if.ev_ready = 1'b1;
    drive_slot();
    rst_n = 1'b1;

    // Overrun with period 15
    count_to_slow(15, "restart_from_cnt0");
    wait_stage(3, "overrun_tick_end");
    chk("overrun_set", int'(overrun), 1);
    @(negedge clk);
    chk("overrun_next_slow", int'(clock_slow), 1);
    chk("overrun_next_stage", int'(stage), 0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
